// File: rtl/scan_pkg.sv
// scan_pkg: shared mode encodings, channel limit and index mapping for the scan mux
package scan_pkg;
  localparam logic MODE_MANUAL  = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;
  localparam int   MAX_CHANNELS = 64;
  function automatic int idx_map(input int idx, input int n, input bit rev);
    return rev ? n - 1 - idx : idx;
  endfunction
endpackage

// File: rtl/scan_divider.sv
// scan_divider: prescaler producing one tick every DIV running cycles
module scan_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] r_cnt;
  assign tick = run && r_cnt == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (run) r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/scan_mux_seq.sv
// scan_mux_seq: registered N:1 bit selector with manual index load and auto-scan sequencer
module scan_mux_seq
  import scan_pkg::*;
#(
  parameter int N       = 36,
  parameter int SEL_W   = 6,
  parameter int DIV     = 1,
  parameter int REVERSE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     data_in,
  input  logic             mode,
  input  logic             enable,
  input  logic             load,
  input  logic [SEL_W-1:0] sel_in,
  output logic             out,
  output logic             valid,
  output logic [SEL_W-1:0] sel_out,
  output logic             wrap
);
  localparam logic [SEL_W:0]   NUM  = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);
  logic [SEL_W-1:0] r_idx;
  logic             r_out, r_valid, r_wrap;
  logic             w_run, w_tick, w_in_range;
  logic [SEL_W-1:0] w_map;
  logic [N-1:0]     w_shift;
  assign w_run = enable && mode == MODE_AUTO;
  scan_divider #(.DIV(DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .clear (load || mode == MODE_MANUAL),
    .tick  (w_tick)
  );
  assign w_in_range = {1'b0, r_idx} < NUM;
  // out-of-range indices may map anywhere; w_in_range masks the result
  assign w_map   = SEL_W'(idx_map(int'(r_idx), N, REVERSE != 0));
  assign w_shift = data_in >> w_map;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_idx   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_out   <= w_in_range && w_shift[0];
      r_valid <= w_in_range;
      r_wrap  <= !load && w_tick && r_idx >= LAST;
      if (load) r_idx <= sel_in;
      else if (w_tick) r_idx <= r_idx >= LAST ? '0 : r_idx + 1'b1;
    end
  assign out     = r_out;
  assign valid   = r_valid;
  assign sel_out = r_idx;
  assign wrap    = r_wrap;
endmodule

// File: tb/tb_scan_mux_seq.sv
// tb_scan_mux_seq: scoreboard bench; stimulus queues expected outputs, monitor compares after each edge
module tb_scan_mux_seq;
  localparam int N  = 36;
  localparam int SW = 6;
  localparam int DV = 3;
  typedef struct packed {
    logic          o;
    logic          v;
    logic [SW-1:0] s;
    logic          w;
  } exp_t;
  logic          clk = 1'b0, reset = 1'b1;
  logic [N-1:0]  data_in = '0;
  logic          mode = 1'b0, enable = 1'b0, load = 1'b0;
  logic [SW-1:0] sel_in = '0;
  logic          out, valid, wrap;
  logic [SW-1:0] sel_out;
  exp_t          q[$];
  int            checks = 0, errors = 0;
  int            m_idx = 0, m_cnt = 0;
  string         phase = "reset";
  always #5 clk = ~clk;
  scan_mux_seq #(.N(N), .SEL_W(SW), .DIV(DV), .REVERSE(1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .enable(enable),
    .load(load), .sel_in(sel_in), .out(out), .valid(valid), .sel_out(sel_out), .wrap(wrap)
  );
  task automatic check(input string nm, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got out=%b valid=%b sel_out=%0d wrap=%b want out=%b valid=%b sel_out=%0d wrap=%b",
               nm, $time, got.o, got.v, got.s, got.w, exp.o, exp.v, exp.s, exp.w);
    end
  endtask
  always begin
    @(posedge clk);
    #2;
    if (q.size() > 0) check(phase, {out, valid, sel_out, wrap}, q.pop_front());
  end
  task automatic cyc(input logic r, input logic m, input logic en, input logic ld,
                     input logic [SW-1:0] s, input logic [N-1:0] d);
    exp_t e;
    @(negedge clk);
    reset = r; mode = m; enable = en; load = ld; sel_in = s; data_in = d;
    e = '0;
    if (r) begin
      m_idx = 0;
      m_cnt = 0;
    end else begin
      e.v = m_idx < N;
      e.o = (m_idx < N) ? d[N-1-m_idx] : 1'b0;
      if (ld) begin
        m_idx = int'(s);
        m_cnt = 0;
      end else if (!m) m_cnt = 0;
      else if (en) begin
        if (m_cnt == DV - 1) begin
          m_cnt = 0;
          if (m_idx >= N - 1) begin
            m_idx = 0;
            e.w   = 1'b1;
          end else m_idx++;
        end else m_cnt++;
      end
      e.s = SW'(m_idx);
    end
    q.push_back(e);
  endtask
  initial begin
    logic [N-1:0] d1, d2;
    d1 = 36'h8_0000_0001;
    d2 = 36'h5_A5C3_9E71;
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    phase = "manual";
    cyc(0, 0, 0, 1, 0, d1);
    cyc(0, 0, 0, 0, 0, d1);
    cyc(0, 0, 0, 1, 35, d1);
    cyc(0, 0, 0, 0, 0, d1);
    cyc(0, 0, 0, 1, 1, d1);
    cyc(0, 0, 0, 0, 0, d1);
    phase = "range";
    cyc(0, 0, 0, 1, 36, d1);
    cyc(0, 0, 0, 0, 0, d1);
    cyc(0, 0, 0, 1, 63, ~d1);
    cyc(0, 0, 0, 0, 0, ~d1);
    repeat (5) cyc(0, 1, 1, 0, 0, d1);
    phase = "auto";
    for (int i = 0; i < 112; i++) cyc(0, 1, 1, 0, 0, (i % 2) ? d2 : ~d2);
    phase = "collide";
    for (int i = 0; i < 8 && m_cnt != DV - 1; i++) cyc(0, 1, 1, 0, 0, d2);
    cyc(0, 1, 1, 1, 10, d2);
    repeat (5) cyc(0, 1, 1, 0, 0, d2);
    phase = "freeze";
    cyc(0, 1, 1, 1, 5, d2);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, d2 ^ (N'(i % 2) << 30));
    repeat (4) cyc(0, 1, 1, 0, 0, d2);
    phase = "midreset";
    cyc(0, 1, 1, 1, 17, d2);
    repeat (2) cyc(0, 1, 1, 0, 0, d2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", {out, valid, sel_out, wrap}, '0);
    repeat (2) cyc(1, 1, 1, 0, 0, d2);
    phase = "post_reset";
    repeat (4) cyc(0, 0, 1, 0, 0, d1);
    repeat (3) cyc(0, 1, 1, 0, 0, d1);
    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
